stage_mem_to_wb_skid_register: RTL and testbench

- Parametrised successor of the fixed MEM→WB pipeline register.
- Carries write-back enable, memory-read select, ALU result, memory data and destination register index from MEM to WB.
- Adds a valid/ready handshake, a 2-entry skid buffer so MEM can stall without a combinational ready path, and a synchronous flush.
- Exposes pending-destination info to the hazard/forwarding unit.

---
 rtl/stage_mem_to_wb_skid_register_pkg.sv | 22 ++
 rtl/stage_mem_to_wb_skid_register_if.sv | 41 ++++
 rtl/stage_mem_to_wb_skid_register_pipe_skid_entry.sv | 47 ++++
 rtl/stage_mem_to_wb_skid_register.sv | 85 ++++++++
 tb/tb_stage_mem_to_wb_skid_register.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/stage_mem_to_wb_skid_register_pkg.sv
// rtl/stage_mem_to_wb_skid_register_pkg.sv - shared widths and MEM->WB payload layout
package stage_mem_to_wb_skid_register_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int DEST_W_DEF = 4;

  typedef struct packed {
    logic                  wb_en;
    logic                  mem_r_en;
    logic [DATA_W_DEF-1:0] alu_res;
    logic [DATA_W_DEF-1:0] mem_data;
    logic [DEST_W_DEF-1:0] dest;
  } mem_wb_payload_t;

  localparam int PAYLOAD_W = $bits(mem_wb_payload_t);

  // Flat payload width for non-default parameterisations; field order matches mem_wb_payload_t.
  function automatic int payload_width(input int data_w, input int dest_w);
    return 2 + 2 * data_w + dest_w;
  endfunction

endpackage

// File: rtl/stage_mem_to_wb_skid_register_if.sv
// rtl/stage_mem_to_wb_skid_register_if.sv - MEM->WB handshake bus with hazard-unit pending info
interface stage_mem_to_wb_skid_register_if
  import stage_mem_to_wb_skid_register_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEST_W = DEST_W_DEF
);

  logic              inValid;
  logic              inReady;
  logic              wbEnIn;
  logic              memREnIn;
  logic [DATA_W-1:0] aluResIn;
  logic [DATA_W-1:0] memDataIn;
  logic [DEST_W-1:0] destIn;

  logic              outValid;
  logic              outReady;
  logic              wbEnOut;
  logic              memREnOut;
  logic [DATA_W-1:0] aluResOut;
  logic [DATA_W-1:0] memDataOut;
  logic [DEST_W-1:0] destOut;

  logic [1:0]        pendWb;
  logic [DEST_W-1:0] pendDest0;
  logic [DEST_W-1:0] pendDest1;

  modport master (
    output inValid, wbEnIn, memREnIn, aluResIn, memDataIn, destIn, outReady,
    input  inReady, outValid, wbEnOut, memREnOut, aluResOut, memDataOut, destOut,
    input  pendWb, pendDest0, pendDest1
  );

  modport slave (
    input  inValid, wbEnIn, memREnIn, aluResIn, memDataIn, destIn, outReady,
    output inReady, outValid, wbEnOut, memREnOut, aluResOut, memDataOut, destOut,
    output pendWb, pendDest0, pendDest1
  );

endinterface

// File: rtl/stage_mem_to_wb_skid_register_pipe_skid_entry.sv
// rtl/stage_mem_to_wb_skid_register_pipe_skid_entry.sv - payload register with valid bit, load and clear
module pipe_skid_entry #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         load,
  input  logic         unload,
  input  logic [W-1:0] data_in,
  output logic         valid,
  output logic [W-1:0] data
);

  logic         valid_d, valid_q;
  logic [W-1:0] data_d, data_q;

  // Flush only kills the valid bit; payload may stay stale since every consumer gates by valid.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      data_d = data_in;
    end
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
    end else if (unload) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/stage_mem_to_wb_skid_register.sv
// rtl/stage_mem_to_wb_skid_register.sv - MEM->WB pipeline register with valid/ready, 2-entry skid and flush
module stage_mem_to_wb_skid_register
  import stage_mem_to_wb_skid_register_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DEST_W  = DEST_W_DEF,
  parameter int SKID_EN = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  stage_mem_to_wb_skid_register_if.slave bus
);

  localparam int PW      = payload_width(DATA_W, DEST_W);
  localparam bit HAS_SKID = (SKID_EN != 0);
  localparam int MEM_LO  = DEST_W;
  localparam int ALU_LO  = DEST_W + DATA_W;

  logic [PW-1:0] in_pay, main_pay, skid_pay, main_nxt;
  logic          main_valid, skid_valid;
  logic          in_ready, accept, drain;
  logic          main_load, skid_load, skid_unload;

  assign in_pay = {bus.wbEnIn, bus.memREnIn, bus.aluResIn, bus.memDataIn, bus.destIn};

  // With the skid enabled inReady comes straight from the skid valid flop, so outReady never reaches it.
  always_comb begin
    in_ready    = 1'b0;
    accept      = 1'b0;
    drain       = 1'b0;
    main_load   = 1'b0;
    main_nxt    = in_pay;
    skid_load   = 1'b0;
    skid_unload = 1'b0;

    in_ready = HAS_SKID ? ~skid_valid : (~main_valid | bus.outReady);
    accept   = bus.inValid & in_ready;
    drain    = main_valid & bus.outReady;

    if (skid_valid) begin
      main_load   = drain;
      main_nxt    = skid_pay;
      skid_unload = drain;
    end else begin
      main_load = accept & (~main_valid | drain);
    end
    skid_load = HAS_SKID & accept & main_valid & ~drain;
  end

  pipe_skid_entry #(.W(PW)) u_main (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .load    (main_load),
    .unload  (drain),
    .data_in (main_nxt),
    .valid   (main_valid),
    .data    (main_pay)
  );

  // Without SKID_EN the skid load is tied low, so this entry reduces to constant zero.
  pipe_skid_entry #(.W(PW)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .load    (skid_load),
    .unload  (skid_unload),
    .data_in (in_pay),
    .valid   (skid_valid),
    .data    (skid_pay)
  );

  assign bus.inReady    = in_ready;
  assign bus.outValid   = main_valid;
  assign bus.wbEnOut    = main_valid & main_pay[PW-1];
  assign bus.memREnOut  = main_pay[PW-2];
  assign bus.aluResOut  = main_pay[ALU_LO +: DATA_W];
  assign bus.memDataOut = main_pay[MEM_LO +: DATA_W];
  assign bus.destOut    = main_pay[DEST_W-1:0];
  assign bus.pendWb     = {skid_valid & skid_pay[PW-1], main_valid & main_pay[PW-1]};
  assign bus.pendDest0  = main_pay[DEST_W-1:0];
  assign bus.pendDest1  = skid_pay[DEST_W-1:0];

endmodule

// File: tb/tb_stage_mem_to_wb_skid_register.sv
// tb/tb_stage_mem_to_wb_skid_register.sv - random + directed bench against a FIFO-capacity reference model
module tb_stage_mem_to_wb_skid_register;
  import stage_mem_to_wb_skid_register_pkg::*;

  typedef mem_wb_payload_t pay_t;
  typedef pay_t pay_q_t[$];

  logic clk;
  logic rst, flush, in_valid, out_ready;
  pay_t in_pay;
  int   total = 0;
  int   bad   = 0;
  pay_q_t qa, qb;

  stage_mem_to_wb_skid_register_if #(.DATA_W(32), .DEST_W(4)) ia ();
  stage_mem_to_wb_skid_register_if #(.DATA_W(32), .DEST_W(4)) ib ();

  assign ia.inValid = in_valid;     assign ib.inValid = in_valid;
  assign ia.outReady = out_ready;   assign ib.outReady = out_ready;
  assign ia.wbEnIn = in_pay.wb_en;  assign ib.wbEnIn = in_pay.wb_en;
  assign ia.memREnIn = in_pay.mem_r_en;   assign ib.memREnIn = in_pay.mem_r_en;
  assign ia.aluResIn = in_pay.alu_res;    assign ib.aluResIn = in_pay.alu_res;
  assign ia.memDataIn = in_pay.mem_data;  assign ib.memDataIn = in_pay.mem_data;
  assign ia.destIn = in_pay.dest;   assign ib.destIn = in_pay.dest;

  stage_mem_to_wb_skid_register #(.DATA_W(32), .DEST_W(4), .SKID_EN(1)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .bus(ia)
  );
  stage_mem_to_wb_skid_register #(.DATA_W(32), .DEST_W(4), .SKID_EN(0)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .bus(ib)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // The register behaves as a FIFO of capacity cap (2 with skid, 1 without).
  function automatic bit model_ready(input int sz, input int cap);
    return (cap == 2) ? (sz < 2) : (sz == 0 || out_ready);
  endfunction

  function automatic pay_q_t model_next(input pay_q_t q, input int cap);
    pay_q_t r;
    bit acc;
    r = q;
    if (rst || flush) begin
      r.delete();
      return r;
    end
    acc = in_valid && model_ready(q.size(), cap);
    if (q.size() > 0 && out_ready) void'(r.pop_front());
    if (acc) r.push_back(in_pay);
    return r;
  endfunction

  task automatic check_side(input string s, input int cap, input pay_q_t q,
                            input logic ov, input logic ir, input logic wbo, input logic mro,
                            input logic [31:0] alu, input logic [31:0] mem, input logic [3:0] dst,
                            input logic [1:0] pw, input logic [3:0] pd0, input logic [3:0] pd1);
    int   sz;
    pay_t hd, nx;
    sz = q.size();
    hd = (sz > 0) ? q[0] : '0;
    nx = (sz > 1) ? q[1] : '0;
    check_eq({s, ".outValid"}, ov, sz > 0);
    check_eq({s, ".inReady"}, ir, model_ready(sz, cap));
    check_eq({s, ".pendWb"}, pw, {sz == 2 && nx.wb_en, sz > 0 && hd.wb_en});
    check_eq({s, ".wbEnOut"}, wbo, sz > 0 && hd.wb_en);
    if (sz > 0) begin
      check_eq({s, ".aluResOut"}, alu, hd.alu_res);
      check_eq({s, ".memDataOut"}, mem, hd.mem_data);
      check_eq({s, ".destOut"}, dst, hd.dest);
      check_eq({s, ".memREnOut"}, mro, hd.mem_r_en);
      check_eq({s, ".pendDest0"}, pd0, hd.dest);
    end
    if (sz == 2) check_eq({s, ".pendDest1"}, pd1, nx.dest);
    if (cap == 1) check_eq({s, ".pendDest1_zero"}, pd1, 4'h0);
  endtask

  task automatic step();
    #1;
    check_side("a", 2, qa, ia.outValid, ia.inReady, ia.wbEnOut, ia.memREnOut, ia.aluResOut,
               ia.memDataOut, ia.destOut, ia.pendWb, ia.pendDest0, ia.pendDest1);
    check_side("b", 1, qb, ib.outValid, ib.inReady, ib.wbEnOut, ib.memREnOut, ib.aluResOut,
               ib.memDataOut, ib.destOut, ib.pendWb, ib.pendDest0, ib.pendDest1);
    @(posedge clk);
    qa = model_next(qa, 2);
    qb = model_next(qb, 1);
    #1;
  endtask

  function automatic pay_t rand_pay(input logic [3:0] dest);
    pay_t p;
    p.wb_en    = 1'($urandom_range(0, 1));
    p.mem_r_en = 1'($urandom_range(0, 1));
    p.alu_res  = $urandom;
    p.mem_data = $urandom;
    p.dest     = dest;
    return p;
  endfunction

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    in_pay = rand_pay(4'hF);
    repeat (2) @(posedge clk);
    #1;
    qa.delete(); qb.delete();
    check_eq("rst.outValid", ia.outValid, 1'b0);
    check_eq("rst.aluResOut", ia.aluResOut, 32'h0);
    check_eq("rst.destOut", ia.destOut, 4'h0);
    check_eq("rst.pendWb", ia.pendWb, 2'b00);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check_eq("rst.inReady", ia.inReady, 1'b1);

    // single transfer
    in_pay = '{wb_en: 1'b1, mem_r_en: 1'b0, alu_res: 32'h0000_00AA, mem_data: 32'h1234_5678, dest: 4'h5};
    in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check_eq("single.outValid", ia.outValid, 1'b1);
    check_eq("single.aluResOut", ia.aluResOut, 32'hAA);
    check_eq("single.destOut", ia.destOut, 4'h5);
    check_eq("single.wbEnOut", ia.wbEnOut, 1'b1);
    step();
    check_eq("single.drained", ia.outValid, 1'b0);

    // stall and skid
    out_ready = 1'b0; in_valid = 1'b1;
    in_pay = rand_pay(4'h1); in_pay.wb_en = 1'b1;
    step();
    in_pay = rand_pay(4'h2); in_pay.wb_en = 1'b1;
    step();
    in_valid = 1'b0;
    #1;
    check_eq("skid.pendWb", ia.pendWb, 2'b11);
    check_eq("skid.pendDest0", ia.pendDest0, 4'h1);
    check_eq("skid.pendDest1", ia.pendDest1, 4'h2);
    check_eq("skid.inReady", ia.inReady, 1'b0);
    check_eq("noskid.inReady_full", ib.inReady, 1'b0);
    out_ready = 1'b1;
    repeat (3) step();
    check_eq("skid.inReady_back", ia.inReady, 1'b1);

    // back-to-back stream
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_pay = rand_pay(4'(i));
      step();
    end
    in_valid = 1'b0;
    repeat (2) step();

    // flush with both entries full and a simultaneous input
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_pay = rand_pay(4'(i + 8)); in_pay.wb_en = 1'b1;
      step();
    end
    flush = 1'b1; in_pay = rand_pay(4'hC);
    step();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    check_eq("flush.outValid", ia.outValid, 1'b0);
    check_eq("flush.wbEnOut", ia.wbEnOut, 1'b0);
    check_eq("flush.pendWb", ia.pendWb, 2'b00);
    check_eq("flush.inReady", ia.inReady, 1'b1);
    step();

    // randomized traffic with occasional flush and reset
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = (i % 100 < 50) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      flush     = ($urandom_range(0, 31) == 0);
      rst       = ($urandom_range(0, 63) == 0);
      in_pay    = rand_pay(4'($urandom_range(0, 15)));
      step();
    end
    rst = 1'b0; flush = 1'b0;

    // reset mid-stall
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_pay = '{wb_en: 1'b1, mem_r_en: 1'b1, alu_res: $urandom | 32'h1, mem_data: $urandom | 32'h1, dest: 4'(i + 3)};
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check_eq("rstmid.outValid", ia.outValid, 1'b0);
    check_eq("rstmid.wbEnOut", ia.wbEnOut, 1'b0);
    check_eq("rstmid.memREnOut", ia.memREnOut, 1'b0);
    check_eq("rstmid.aluResOut", ia.aluResOut, 32'h0);
    check_eq("rstmid.memDataOut", ia.memDataOut, 32'h0);
    check_eq("rstmid.destOut", ia.destOut, 4'h0);
    check_eq("rstmid.pendWb", ia.pendWb, 2'b00);
    check_eq("rstmid.pendDest1", ia.pendDest1, 4'h0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
